da_coef_loader: RTL and testbench

Coefficient pre-compute and load engine for the `da` distributed-arithmetic FIR core. Holds 64 signed filter taps written by the host, computes all 2048 partial-sum lookup entries (8 ROMs × 256 words), and streams them into `da` over its coefficient-load interface (`CADDR`/`CIN`/`CLOAD`/`valid_in`). It is the writer for that interface: it replaces host-side table generation and sits between the control path and `da`.

---
 rtl/da_pkg.sv | 30 +++
 rtl/da_partial_sum.sv | 29 ++
 rtl/da_coef_loader.sv | 97 +++++++++
 tb/tb_da_coef_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Constants and types shared by the da FIR core, its coefficient loader
// and their benches.
package da_pkg;

    localparam int NUM_ROMS   = 8;
    localparam int ROM_DEPTH  = 256;
    localparam int NUM_TAPS   = 64;
    localparam int COEF_W     = 17;
    localparam int CIN_W      = 20;
    localparam int CADDR_W    = 11;
    localparam int ROM_AW     = 8;
    localparam int ROM_SEL_W  = 3;
    localparam int TAP_AW     = 6;
    localparam int TABLE_SIZE = NUM_ROMS * ROM_DEPTH;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // The eight taps that feed one ROM, tap j weighted by address bit j.
    typedef logic [ROM_AW-1:0][COEF_W-1:0] tap_bank_t;

    function automatic logic [CIN_W-1:0] sext_tap(
        input logic [COEF_W-1:0] t
    );
        return {{(CIN_W - COEF_W){t[COEF_W-1]}}, t};
    endfunction

endpackage

// File: rtl/da_partial_sum.sv
// One lookup entry: sum of the taps selected by the address bits,
// computed by a three-level combinational adder tree.
module da_partial_sum
    import da_pkg::*;
(
    input  tap_bank_t                taps,
    input  logic [ROM_AW-1:0]        a,
    output logic signed [CIN_W-1:0]  sum
);

    logic [CIN_W-1:0] masked [ROM_AW];
    logic [CIN_W-1:0] lvl1   [ROM_AW/2];
    logic [CIN_W-1:0] lvl2   [ROM_AW/4];

    always_comb begin
        for (int j = 0; j < ROM_AW; j++) begin
            masked[j] = a[j] ? sext_tap(taps[j]) : '0;
        end
        for (int j = 0; j < ROM_AW/2; j++) begin
            lvl1[j] = masked[2*j] + masked[2*j+1];
        end
        for (int j = 0; j < ROM_AW/4; j++) begin
            lvl2[j] = lvl1[2*j] + lvl1[2*j+1];
        end
    end

    assign sum = lvl2[0] + lvl2[1];

endmodule

// File: rtl/da_coef_loader.sv
// Holds the host-written taps and streams the full partial-sum table
// into the da core over its coefficient-load port.
module da_coef_loader
    import da_pkg::*;
(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     coef_we,
    input  logic [TAP_AW-1:0]        coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    input  logic                     start,
    input  logic                     hold,
    output logic [CADDR_W-1:0]       CADDR,
    output logic signed [CIN_W-1:0]  CIN,
    output logic                     CLOAD,
    output logic                     valid_in,
    output logic                     busy,
    output logic                     load_done
);

    logic [COEF_W-1:0]    taps [NUM_TAPS];
    state_t               state;
    logic [CADDR_W-1:0]   cnt;
    logic [ROM_SEL_W-1:0] rom_sel;
    logic [ROM_AW-1:0]    rom_addr;
    tap_bank_t            bank;
    logic signed [CIN_W-1:0] entry;
    logic                 last;

    assign busy     = (state == ST_RUN);
    assign valid_in = CLOAD;
    assign rom_sel  = cnt[CADDR_W-1:ROM_AW];
    assign rom_addr = cnt[ROM_AW-1:0];
    assign last     = (cnt == CADDR_W'(TABLE_SIZE - 1));

    // Taps are frozen for the whole stream so every word sees one table.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                taps[i] <= '0;
            end
        end else if (coef_we && !busy) begin
            taps[coef_addr] <= coef_data;
        end
    end

    always_comb begin
        for (int j = 0; j < ROM_AW; j++) begin
            bank[j] = taps[{rom_sel, 3'(j)}];
        end
    end

    da_partial_sum u_sum (
        .taps (bank),
        .a    (rom_addr),
        .sum  (entry)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            CADDR     <= '0;
            CIN       <= '0;
            CLOAD     <= 1'b0;
            load_done <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    CLOAD     <= 1'b0;
                    load_done <= 1'b0;
                    cnt       <= '0;
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (hold) begin
                        CLOAD     <= 1'b0;
                        load_done <= 1'b0;
                    end else begin
                        CADDR     <= cnt;
                        CIN       <= entry;
                        CLOAD     <= 1'b1;
                        cnt       <= cnt + 1'b1;
                        load_done <= last;
                        if (last) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_da_coef_loader.sv
// Directed bench for da_coef_loader: reset, ramp and extreme tables,
// hold back-pressure, busy guards, back-to-back and reset abort.
module tb_da_coef_loader;
    import da_pkg::*;

    logic                    clk = 1'b0;
    logic                    resetn;
    logic                    coef_we;
    logic [TAP_AW-1:0]       coef_addr;
    logic [COEF_W-1:0]       coef_data;
    logic                    start;
    logic                    hold;
    logic [CADDR_W-1:0]      CADDR;
    logic signed [CIN_W-1:0] CIN;
    logic                    CLOAD;
    logic                    valid_in;
    logic                    busy;
    logic                    load_done;

    int n_checks = 0;
    int n_fails  = 0;

    localparam int TW = 4 + CADDR_W + CIN_W;
    logic [TW-1:0] got;
    logic [TW-1:0] exp;

    da_coef_loader dut (
        .clk       (clk),
        .resetn    (resetn),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .start     (start),
        .hold      (hold),
        .CADDR     (CADDR),
        .CIN       (CIN),
        .CLOAD     (CLOAD),
        .valid_in  (valid_in),
        .busy      (busy),
        .load_done (load_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_tap(input int idx, input int val);
        coef_we   = 1'b1;
        coef_addr = TAP_AW'(idx);
        coef_data = COEF_W'(val);
        tick();
        coef_we   = 1'b0;
    endtask

    function automatic logic [TW-1:0] pack_exp(
        input logic cl, input logic ld, input logic bz,
        input int addr, input int cin
    );
        return {cl, cl, ld, bz, CADDR_W'(addr), CIN_W'(cin)};
    endfunction

    task automatic test_reset;
        resetn    = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        start     = 1'b0;
        hold      = 1'b0;
        #12;
        n_checks++;
        if ({CADDR, CIN, CLOAD, valid_in, busy, load_done} !== '0) begin
            n_fails++;
            $display("FAIL reset_state: got addr=%0d cin=%0d cl=%b vi=%b bz=%b ld=%b want all 0",
                     CADDR, CIN, CLOAD, valid_in, busy, load_done);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        hold = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({CLOAD, busy, load_done} !== 3'b000) begin
            n_fails++;
            $display("FAIL idle_hold: got cl=%b bz=%b ld=%b want 000",
                     CLOAD, busy, load_done);
        end
        hold = 1'b0;
    endtask

    task automatic test_ramp;
        for (int i = 0; i < 7; i++) write_tap(i, 1 << i);
        coef_we   = 1'b1;
        coef_addr = 6'd7;
        coef_data = 17'd128;
        start     = 1'b1;
        tick();
        coef_we = 1'b0;
        start   = 1'b0;
        n_checks++;
        if ({busy, CLOAD} !== 2'b10) begin
            n_fails++;
            $display("FAIL ramp_accept: got bz=%b cl=%b want bz=1 cl=0", busy, CLOAD);
        end
        for (int n = 0; n < TABLE_SIZE; n++) begin
            tick();
            got = {CLOAD, valid_in, load_done, busy, CADDR, CIN};
            exp = pack_exp(1'b1, n == 2047, n != 2047, n, (n < 256) ? n : 0);
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL ramp_word %0d: got %h want %h", n, got, exp);
            end
        end
        tick();
        n_checks++;
        if ({CLOAD, load_done, busy, CADDR} !== {3'b000, 11'd2047}) begin
            n_fails++;
            $display("FAIL ramp_after: got cl=%b ld=%b bz=%b addr=%0d want 0 0 0 2047",
                     CLOAD, load_done, busy, CADDR);
        end
    endtask

    task automatic test_neg_extreme;
        for (int i = 0; i < NUM_TAPS; i++) write_tap(i, -65536);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < TABLE_SIZE; n++) begin
            tick();
            got = {CLOAD, valid_in, load_done, busy, CADDR, CIN};
            exp = pack_exp(1'b1, n == 2047, n != 2047, n,
                           -65536 * $countones(n[7:0]));
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL neg_word %0d: got %h want %h", n, got, exp);
            end
        end
        tick();
    endtask

    task automatic test_hold;
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 2051; c++) begin
            tick();
            got = {CLOAD, valid_in, load_done, busy, CADDR, CIN};
            if (c >= 102 && c <= 104) begin
                exp = pack_exp(1'b0, 1'b0, 1'b1, 100, -196608);
            end else begin
                n = (c <= 101) ? c - 1 : c - 4;
                exp = pack_exp(1'b1, c == 2051, c != 2051, n,
                               -65536 * $countones(n[7:0]));
            end
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL hold_cycle %0d: got %h want %h", c, got, exp);
            end
            if (c == 101) hold = 1'b1;
            if (c == 104) hold = 1'b0;
        end
        tick();
    endtask

    task automatic test_busy_guard;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 2048; c++) begin
            tick();
            got = {CLOAD, valid_in, load_done, busy, CADDR, CIN};
            exp = pack_exp(1'b1, c == 2048, c != 2048, c - 1,
                           -65536 * $countones(8'(c - 1)));
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL guard_word %0d: got %h want %h", c - 1, got, exp);
            end
            if (c == 10) begin
                start     = 1'b1;
                coef_we   = 1'b1;
                coef_addr = '0;
                coef_data = 17'd5;
            end
            if (c == 11) begin
                start   = 1'b0;
                coef_we = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({busy, CLOAD, load_done} !== 3'b100) begin
            n_fails++;
            $display("FAIL b2b_accept: got bz=%b cl=%b ld=%b want 1 0 0",
                     busy, CLOAD, load_done);
        end
        tick();
        n_checks++;
        if ({CLOAD, CADDR, CIN} !== {1'b1, 11'd0, 20'sd0}) begin
            n_fails++;
            $display("FAIL b2b_word0: got cl=%b addr=%0d cin=%0d want 1 0 0",
                     CLOAD, CADDR, CIN);
        end
        tick();
        n_checks++;
        if ({CLOAD, CADDR, CIN} !== {1'b1, 11'd1, 20'(-65536)}) begin
            n_fails++;
            $display("FAIL b2b_old_tap0: got cl=%b addr=%0d cin=%0d want 1 1 -65536",
                     CLOAD, CADDR, CIN);
        end
    endtask

    task automatic test_reset_abort;
        for (int c = 3; c <= 501; c++) begin
            tick();
            got = {CLOAD, valid_in, load_done, busy, CADDR, CIN};
            exp = pack_exp(1'b1, 1'b0, 1'b1, c - 1,
                           -65536 * $countones(8'(c - 1)));
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL abort_pre %0d: got %h want %h", c - 1, got, exp);
            end
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({CADDR, CIN, CLOAD, valid_in, busy, load_done} !== '0) begin
            n_fails++;
            $display("FAIL abort_async: got addr=%0d cin=%0d cl=%b bz=%b ld=%b want all 0",
                     CADDR, CIN, CLOAD, busy, load_done);
        end
        tick();
        resetn = 1'b1;
        tick();
        n_checks++;
        if ({busy, CLOAD} !== 2'b00) begin
            n_fails++;
            $display("FAIL abort_no_resume: got bz=%b cl=%b want 0 0", busy, CLOAD);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < TABLE_SIZE; n++) begin
            tick();
            got = {CLOAD, valid_in, load_done, busy, CADDR, CIN};
            exp = pack_exp(1'b1, n == 2047, n != 2047, n, 0);
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL abort_word %0d: got %h want %h", n, got, exp);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_neg_extreme();
        test_hold();
        test_busy_guard();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
